// File: rtl/ds18b20_responder.sv
`timescale 1ns/1ps
// DS18B20-style 1-Wire slave: bus reset/presence, Skip ROM, Convert T and
// Read Scratchpad, with the Dallas CRC8 accumulated as scratchpad bits go out.
module ds18b20_responder #(
  parameter int CLK_MHZ      = 50,
  parameter int RST_MIN_US   = 450,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_US      = 120,
  parameter int SAMPLE_US    = 30,
  parameter int READ0_US     = 30,
  parameter int CONV_US      = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_in,
  output logic        dq_drv_low,
  input  logic [15:0] temp_value,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        conv_busy,
  output logic        presence_active,
  output logic [2:0]  fsm_state
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RST_LOW    = 3'd1;
  localparam logic [2:0] S_PRES_WAIT  = 3'd2;
  localparam logic [2:0] S_PRES_DRIVE = 3'd3;
  localparam logic [2:0] S_ROM_CMD    = 3'd4;
  localparam logic [2:0] S_FUNC_CMD   = 3'd5;
  localparam logic [2:0] S_CONV_POLL  = 3'd6;
  localparam logic [2:0] S_READ_SP    = 3'd7;

  localparam int PRE_W     = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int BLANK_CYC = CLK_MHZ + 3;
  localparam int BLANK_W   = $clog2(BLANK_CYC + 1);
  localparam int CONV_W    = (CONV_US > 1) ? $clog2(CONV_US + 1) : 1;

  logic [2:0]         state;
  logic [PRE_W-1:0]   pre_cnt;
  logic               tick;
  logic               dq_s1, dq_s2, dq_prev;
  logic               drv_q;
  logic [BLANK_W-1:0] blank_cnt;
  logic               quiet, fall_ok, rise, rst_hit;
  logic [9:0]         low_us;
  logic [15:0]        us_cnt;
  logic               slot_active, rd_drv;
  logic [6:0]         shift;
  logic [7:0]         new_byte, sp_byte, crc, crc_next;
  logic [2:0]         bit_cnt;
  logic [6:0]         rd_idx;
  logic               tx_bit, wr_state, sample_now, byte_done;
  logic [15:0]        sp_temp, pend_temp;
  logic [CONV_W-1:0]  conv_cnt;

  assign tick            = (pre_cnt == PRE_W'(CLK_MHZ - 1));
  // Our own drive, and the synchroniser tail after we let go, must not look like master activity.
  assign quiet           = dq_drv_low | drv_q | (blank_cnt != '0);
  assign fall_ok         = dq_prev & ~dq_s2 & ~quiet;
  assign rise            = ~dq_prev & dq_s2;
  assign rst_hit         = (low_us >= 10'(RST_MIN_US)) && (state != S_RST_LOW);
  assign dq_drv_low      = (state == S_PRES_DRIVE) | rd_drv;
  assign presence_active = (state == S_PRES_DRIVE);
  assign fsm_state       = state;
  assign wr_state        = (state == S_ROM_CMD) || (state == S_FUNC_CMD);
  assign sample_now      = wr_state && slot_active && (us_cnt == 16'(SAMPLE_US));
  assign byte_done       = sample_now && (bit_cnt == 3'd7);
  assign new_byte        = {dq_s2, shift};
  assign crc_next        = {1'b0, crc[7:1]} ^ ((crc[0] ^ tx_bit) ? 8'h8C : 8'h00);

  always_comb begin
    sp_byte = 8'hFF;
    case (rd_idx[5:3])
      3'd0:    sp_byte = sp_temp[7:0];
      3'd1:    sp_byte = sp_temp[15:8];
      3'd2:    sp_byte = 8'h4B;
      3'd3:    sp_byte = 8'h46;
      3'd4:    sp_byte = 8'h7F;
      3'd5:    sp_byte = 8'hFF;
      3'd6:    sp_byte = 8'h0C;
      default: sp_byte = 8'h10;
    endcase
    tx_bit = 1'b1;
    if (state == S_CONV_POLL)   tx_bit = ~conv_busy;
    else if (rd_idx < 7'd64)    tx_bit = sp_byte[rd_idx[2:0]];
    else if (rd_idx < 7'd72)    tx_bit = crc[rd_idx[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      dq_s1       <= 1'b1;
      dq_s2       <= 1'b1;
      dq_prev     <= 1'b1;
      drv_q       <= 1'b0;
      blank_cnt   <= '0;
      low_us      <= '0;
      us_cnt      <= '0;
      slot_active <= 1'b0;
      rd_drv      <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      rd_idx      <= '0;
      crc         <= '0;
      cmd_byte    <= '0;
      cmd_valid   <= 1'b0;
      conv_busy   <= 1'b0;
      conv_cnt    <= '0;
      sp_temp     <= 16'h0550;
      pend_temp   <= 16'h0550;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      dq_s1   <= dq_in;
      dq_s2   <= dq_s1;
      dq_prev <= dq_s2;
      drv_q   <= dq_drv_low;
      if (drv_q && !dq_drv_low)  blank_cnt <= BLANK_W'(BLANK_CYC);
      else if (blank_cnt != '0)  blank_cnt <= blank_cnt - BLANK_W'(1);
      if (dq_s2)                                    low_us <= '0;
      else if (!quiet && tick && low_us != 10'd1023) low_us <= low_us + 10'd1;

      cmd_valid <= 1'b0;
      if (byte_done) begin
        cmd_byte  <= new_byte;
        cmd_valid <= 1'b1;
      end

      // Conversion runs independently of bus traffic and bus resets.
      if (conv_busy && tick) begin
        if (conv_cnt <= CONV_W'(1)) begin
          conv_busy <= 1'b0;
          conv_cnt  <= '0;
          sp_temp   <= pend_temp;
        end else begin
          conv_cnt <= conv_cnt - CONV_W'(1);
        end
      end

      if (rst_hit) begin
        state       <= S_RST_LOW;
        slot_active <= 1'b0;
        rd_drv      <= 1'b0;
        bit_cnt     <= '0;
      end else begin
        case (state)
          S_RST_LOW: if (rise) begin
            state  <= S_PRES_WAIT;
            us_cnt <= '0;
          end
          S_PRES_WAIT: begin
            if (us_cnt == 16'(PRES_WAIT_US)) begin
              state  <= S_PRES_DRIVE;
              us_cnt <= '0;
            end else if (tick) us_cnt <= us_cnt + 16'd1;
          end
          S_PRES_DRIVE: begin
            if (us_cnt == 16'(PRES_US)) begin
              state       <= S_ROM_CMD;
              bit_cnt     <= '0;
              slot_active <= 1'b0;
            end else if (tick) us_cnt <= us_cnt + 16'd1;
          end
          S_ROM_CMD, S_FUNC_CMD: begin
            if (fall_ok) begin
              slot_active <= 1'b1;
              us_cnt      <= '0;
            end else if (sample_now) begin
              slot_active <= 1'b0;
              shift       <= new_byte[7:1];
              bit_cnt     <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (state == S_ROM_CMD) begin
                  state <= (new_byte == 8'hCC) ? S_FUNC_CMD : S_IDLE;
                end else if (new_byte == 8'h44) begin
                  pend_temp <= temp_value;
                  conv_busy <= 1'b1;
                  conv_cnt  <= CONV_W'(CONV_US);
                  state     <= S_CONV_POLL;
                end else if (new_byte == 8'hBE) begin
                  rd_idx <= '0;
                  crc    <= '0;
                  state  <= S_READ_SP;
                end else begin
                  state <= S_IDLE;
                end
              end
            end else if (slot_active && tick) us_cnt <= us_cnt + 16'd1;
          end
          S_CONV_POLL, S_READ_SP: begin
            if (fall_ok) begin
              if (!tx_bit) begin
                rd_drv <= 1'b1;
                us_cnt <= '0;
              end
              if (state == S_READ_SP && rd_idx < 7'd72) begin
                rd_idx <= rd_idx + 7'd1;
                if (rd_idx < 7'd64) crc <= crc_next;
              end
            end else if (rd_drv) begin
              if (us_cnt == 16'(READ0_US)) rd_drv <= 1'b0;
              else if (tick)               us_cnt <= us_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ds18b20_responder.sv
`timescale 1ns/1ps
// Bench for ds18b20_responder: a task-level 1-Wire master on an open-drain bus,
// checked against a byte-level scratchpad and conversion-time model.
module tb_ds18b20_responder;
  localparam int CLK_MHZ = 2;
  localparam int CONV_US = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_low;
  logic        dq_in;
  logic        dq_drv_low;
  logic [15:0] temp_value;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        conv_busy;
  logic        presence_active;
  logic [2:0]  fsm_state;

  assign dq_in = ~(m_low | dq_drv_low);

  ds18b20_responder #(.CLK_MHZ(CLK_MHZ), .CONV_US(CONV_US)) dut (
    .clk(clk), .rst(rst), .dq_in(dq_in), .dq_drv_low(dq_drv_low),
    .temp_value(temp_value), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .conv_busy(conv_busy), .presence_active(presence_active), .fsm_state(fsm_state)
  );

  // ---- clock / reset ----
  always #250 clk = ~clk;

  initial begin
    #80_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---- scoreboard state ----
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  int          spurious_valid = 0;
  bit          watch_drive = 1'b0;
  bit          drive_seen = 1'b0;

  // ---- reference model ----
  logic [15:0] mdl_temp;
  logic [15:0] mdl_pend;
  bit          mdl_conv;
  longint      mdl_conv_end;
  logic [7:0]  sp_exp [9];
  logic [7:0]  got_sp [9];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] data [9], input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ data[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  task automatic mdl_reset();
    mdl_temp = 16'h0550;
    mdl_pend = 16'h0550;
    mdl_conv = 1'b0;
  endtask

  function automatic bit mdl_busy();
    if (mdl_conv && longint'($time) >= mdl_conv_end) begin
      mdl_temp = mdl_pend;
      mdl_conv = 1'b0;
    end
    return mdl_conv;
  endfunction

  task automatic mdl_build_sp();
    void'(mdl_busy());
    sp_exp[0] = mdl_temp[7:0];
    sp_exp[1] = mdl_temp[15:8];
    sp_exp[2] = 8'h4B;
    sp_exp[3] = 8'h46;
    sp_exp[4] = 8'h7F;
    sp_exp[5] = 8'hFF;
    sp_exp[6] = 8'h0C;
    sp_exp[7] = 8'h10;
    sp_exp[8] = crc8(sp_exp, 8);
  endtask

  // cmd_valid monitor and drive watcher
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (exp_q.size() == 0) spurious_valid++;
      else check("cmd_byte", 16'(cmd_byte), 16'(exp_q.pop_front()));
    end
    if (watch_drive && dq_drv_low) drive_seen = 1'b1;
  end

  // ---- driver tasks ----
  task automatic wait_us(input int n);
    repeat (n * CLK_MHZ) @(negedge clk);
  endtask

  task automatic do_reset(input int low_us, input bit detailed);
    m_low = 1'b1;
    wait_us(low_us);
    m_low = 1'b0;
    if (detailed) begin
      wait_us(28);  check("pres_early", 16'(dq_drv_low), 16'd0);
      wait_us(5);   check("pres_on", 16'(dq_drv_low), 16'd1);
                    check("pres_flag_on", 16'(presence_active), 16'd1);
      wait_us(115); check("pres_late", 16'(dq_drv_low), 16'd1);
      wait_us(7);   check("pres_off", 16'(dq_drv_low), 16'd0);
                    check("pres_flag_off", 16'(presence_active), 16'd0);
      wait_us(5);
    end else begin
      wait_us(90);  check("pres_mid", 16'(dq_drv_low), 16'd1);
      wait_us(70);
    end
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    if (b) begin
      wait_us(5);  m_low = 1'b0; wait_us(60);
    end else begin
      wait_us(60); m_low = 1'b0; wait_us(5);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) write_bit(b[i]);
  endtask

  task automatic convert_t();
    write_byte(8'h44);
    mdl_pend     = temp_value;
    mdl_conv     = 1'b1;
    mdl_conv_end = longint'($time) - 64'd34_000 + 64'(CONV_US) * 64'd1000;
  endtask

  task automatic read_bit(output logic v);
    m_low = 1'b1;
    wait_us(2);
    m_low = 1'b0;
    wait_us(13);
    v = dq_in;
    wait_us(33 + int'($urandom_range(0, 6)));
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic v;
    for (int i = 0; i < 8; i++) begin
      read_bit(v);
      b[i] = v;
    end
  endtask

  task automatic read_scratchpad(input string tag);
    logic [7:0] b;
    mdl_build_sp();
    for (int k = 0; k < 9; k++) begin
      read_byte(b);
      got_sp[k] = b;
      check($sformatf("%s_byte%0d", tag, k), 16'(b), 16'(sp_exp[k]));
    end
    check({tag, "_crc_residue"}, 16'(crc8(got_sp, 9)), 16'd0);
  endtask

  task automatic expect_silent(input string tag);
    logic [7:0] b;
    drive_seen  = 1'b0;
    watch_drive = 1'b1;
    for (int k = 0; k < 2; k++) begin
      read_byte(b);
      check({tag, "_read"}, 16'(b), 16'hFF);
    end
    watch_drive = 1'b0;
    check({tag, "_no_drive"}, 16'(drive_seen), 16'd0);
  endtask

  // ---- stimulus ----
  initial begin
    logic        v;
    logic [7:0]  b;
    logic [19:0] bits20;

    rst = 1'b1;
    m_low = 1'b0;
    temp_value = 16'h0000;
    mdl_reset();
    repeat (4) @(negedge clk);
    check("rst_drv", 16'(dq_drv_low), 16'd0);
    check("rst_cmd_byte", 16'(cmd_byte), 16'd0);
    check("rst_cmd_valid", 16'(cmd_valid), 16'd0);
    check("rst_conv_busy", 16'(conv_busy), 16'd0);
    check("rst_presence", 16'(presence_active), 16'd0);
    rst = 1'b0;
    wait_us(5);

    // Presence timing, then a plain 100 us low that must not look like a reset
    do_reset(500, 1'b1);
    drive_seen  = 1'b0;
    watch_drive = 1'b1;
    m_low = 1'b1; wait_us(100); m_low = 1'b0; wait_us(160);
    watch_drive = 1'b0;
    check("short_low_no_presence", 16'(drive_seen), 16'd0);

    // Convert T with random temperature; poll busy then done
    temp_value = 16'($urandom);
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    convert_t();
    check("conv_busy_set", 16'(conv_busy), 16'(mdl_busy()));
    temp_value = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      b[0] = !mdl_busy();
      read_bit(v);
      check("poll_busy", 16'(v), 16'(b[0]));
    end
    wait_us(100);
    b[0] = !mdl_busy();
    read_bit(v);
    check("poll_done", 16'(v), 16'(b[0]));
    check("conv_busy_clear", 16'(conv_busy), 16'(mdl_busy()));
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    write_byte(8'hBE);
    mdl_build_sp();
    read_byte(b); check("rand_temp_lsb", 16'(b), 16'(sp_exp[0]));
    read_byte(b); check("rand_temp_msb", 16'(b), 16'(sp_exp[1]));

    // Full scratchpad after converting 0x0191
    temp_value = 16'h0191;
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    convert_t();
    temp_value = 16'($urandom);
    wait_us(250);
    check("conv_done_idle", 16'(conv_busy), 16'(mdl_busy()));
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_scratchpad("sp");
    read_bit(v);
    check("sp_after_crc", 16'(v), 16'd1);

    // Abort a read after 20 bits with a long reset, then restart
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    write_byte(8'hBE);
    mdl_build_sp();
    for (int i = 0; i < 20; i++) begin
      read_bit(v);
      bits20[i] = v;
    end
    check("abort_first16", bits20[15:0], {sp_exp[1], sp_exp[0]});
    check("abort_nibble", 16'(bits20[19:16]), 16'(sp_exp[2][3:0]));
    do_reset(600, 1'b1);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(b); check("restart_byte0", 16'(b), 16'(sp_exp[0]));
    read_byte(b); check("restart_byte1", 16'(b), 16'(sp_exp[1]));

    // Unsupported ROM and function commands leave the bus alone
    do_reset(500, 1'b0);
    write_byte(8'h33);
    expect_silent("rom33");
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    write_byte(8'h55);
    expect_silent("func55");

    // Synchronous rst in the middle of the presence pulse
    m_low = 1'b1; wait_us(500); m_low = 1'b0;
    wait_us(60);
    check("pres_before_rst", 16'(presence_active), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pres_drv", 16'(dq_drv_low), 16'd0);
    check("rst_mid_pres_flag", 16'(presence_active), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    wait_us(200);

    // Power-up scratchpad without any conversion
    do_reset(500, 1'b0);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_scratchpad("pwrup");

    wait_us(20);
    check("cmd_all_seen", 16'(exp_q.size()), 16'd0);
    check("cmd_valid_spurious", 16'(spurious_valid), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ds18b20_responder.md
# ds18b20_responder

Synthesizable 1-Wire slave that answers the DS18B20 master controller as a real sensor would. Used as an on-board loopback target and as the bench device for the temperature-readout chain. It detects reset pulses and answers with presence. It accepts Skip ROM, Convert T and Read Scratchpad, and serves a 9-byte scratchpad with Dallas CRC8 built from a `temp_value` input.

## Interface
- `CLK_MHZ`, 50: clock frequency; prescaler produces one 1 µs tick every `CLK_MHZ` cycles.
- `RST_MIN_US`, 450: minimum low time recognised as a bus reset.
- `PRES_WAIT_US`, 30: delay from reset release to presence start.
- `PRES_US`, 120: presence pulse width.
- `SAMPLE_US`, 30: write-slot sample point after falling edge.
- `READ0_US`, 30: hold-low time when sending a 0 bit.
- `CONV_US`, 750000: Convert T duration (reduced in simulation).
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `dq_in` in 1: 1-Wire bus level (asynchronous, 2-flop synchronised internally).
- `dq_drv_low` out 1: 1 = pull bus low (open-drain enable); top level drives `dq` to 0 when set, else Z.
- `temp_value` in 16: two's-complement temperature, 1/16 °C, DS18B20 format.
- `cmd_byte` out 8: last received byte.
- `cmd_valid` out 1: one-cycle pulse when `cmd_byte` updates.
- `conv_busy` out 1: Convert T in progress.
- `presence_active` out 1: high while the presence pulse is driven.

## Operation
- **Reset values:**
  - All outputs are 0; state is IDLE.
  - Scratchpad temperature is 0x0550 (85 °C power-up value).
  - Conversion counter is cleared.
- **Low-time counter:**
  - The counter runs in µs while the synchronised `dq` is low and this block is not driving.
  - It saturates at 1023.
  - Falling edges are ignored while `dq_drv_low`=1 and for 1 µs after release.
- **Bus reset:**
  - Any low lasting ≥ `RST_MIN_US`, in any state, aborts the current transaction.
  - On the rising edge the block enters PRES_WAIT (`PRES_WAIT_US`), then PRES_DRIVE (`PRES_US`, `dq_drv_low`=`presence_active`=1), then ROM_CMD.
  - A conversion in progress is not affected.
- **Write slots (ROM_CMD, FUNC_CMD):**
  - The falling edge starts a slot.
  - At `SAMPLE_US` the block samples `dq`: low = 0, high = 1.
  - Bits are shifted in LSB first.
  - On the 8th bit: `cmd_byte` is loaded, `cmd_valid` pulses, and the byte is dispatched.
- **ROM_CMD dispatch:**
  - 0xCC goes to FUNC_CMD.
  - Any other value goes to IDLE (silent until the next reset).
- **FUNC_CMD dispatch:**
  - 0x44 latches `temp_value` into a pending register, sets `conv_busy`, loads the conversion counter and goes to CONV_POLL.
  - 0xBE goes to READ_SP with bit index 0 and CRC cleared.
  - Any other value goes to IDLE.
- **Read slots:** on the falling edge, a 0 bit drives `dq_drv_low` for `READ0_US`; a 1 bit drives nothing.
- **CONV_POLL:** each read slot returns `conv_busy` inverted (0 while busy, 1 when done).
- **Conversion:**
  - The counter decrements on each µs tick.
  - At zero, the scratchpad temperature is set to the pending value and `conv_busy` clears.
- **READ_SP:**
  - Bits 0–63 are bytes 0–7, sent LSB first: temp LSB, temp MSB, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10.
  - Bits 64–71 are the CRC byte.
  - The CRC is Dallas CRC8 (x^8+x^5+x^4+1, reflected, init 0x00), updated serially with each transmitted bit 0–63.
  - After bit 71, further read slots return 1.
  - The master may stop at any bit; only a reset restarts.
- **IDLE:** no drive, no `cmd_valid`; only reset detection is active.

## Timing
- Synchroniser plus edge detect adds 3 clk cycles of latency; all µs intervals are measured from the detected edge and are accurate to ±1 µs tick.
- `dq_drv_low` asserts within 1 clk after the read-slot falling edge is detected, so ≤ 4 clk (80 ns at 50 MHz) after the actual bus edge.
- `cmd_valid` fires 1 clk after the 8th sample.
- A low lasting between `SAMPLE_US` and `RST_MIN_US` is a plain slot, not a reset.
- A reset detected at the exact cycle a byte completes takes priority: no dispatch; `cmd_valid` still pulses.
- A Convert T issued while `conv_busy` reloads the counter and re-latches `temp_value`.

## Test plan
- **Presence:** `dq` low 500 µs then released → `dq_drv_low` high from 30 µs to 150 µs after release, `presence_active` matching; a 100 µs low produces no presence.
- **Convert flow (`CONV_US`=200):**
  - Reset, write 0xCC then 0x44 → `cmd_valid` pulses with 0xCC and 0x44; `conv_busy`=1.
  - Read slots inside 200 µs return 0; read slots afterwards return 1.
- **Scratchpad read:**
  - `temp_value`=0x0191, Convert T complete, reset, 0xCC, 0xBE, 72 read slots.
  - Required bytes: 91 01 4B 46 7F FF 0C 10, then a CRC byte equal to the reference CRC8 of those eight bytes; slot 73 reads 1.
- **Power-up read:** reset, 0xCC, 0xBE with no conversion → first two bytes 0x50, 0x05, with correct CRC.
- **Abort:** 600 µs reset inserted after 20 read bits → presence pulse; a subsequent 0xCC, 0xBE restarts at byte 0.
- **Unsupported commands:**
  - ROM cmd 0x33 → `cmd_valid` with 0x33, then no bus drive on the next 16 slots.
  - Function cmd 0x55 after 0xCC → same behaviour.
  - Synchronous `rst` mid-presence → `dq_drv_low`=0 on the next clk.
